fetch_unit: RTL



---
 rtl/fetch_unit_pkg.sv | 34 +++
 rtl/fetch_unit_branch_lut.sv | 11 +
 rtl/fetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage: widths, FSM state encoding,
// the beq opcode and the branch-offset table.
package fetch_unit_pkg;

   localparam int PC_W      = 10;
   localparam int INSTR_W   = 9;
   localparam int OP_W      = 3;
   localparam int LUT_IDX_W = 4;
   localparam int OFF_W     = 8;
   localparam int CNT_W     = 16;

   localparam logic [OP_W-1:0] OP_BEQ = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

   typedef logic signed [OFF_W-1:0] branch_off_t;

   // Entry 2 (-4) and entry 1 (-1) are relied on by existing programs; edit others freely.
   localparam branch_off_t BRANCH_LUT [0:(1<<LUT_IDX_W)-1] = '{
      8'sh02, 8'shFF, 8'shFC, 8'sh03,
      8'sh08, 8'shF8, 8'sh10, 8'shF0,
      8'sh20, 8'shE0, 8'sh40, 8'shC0,
      8'sh7F, 8'sh80, 8'sh05, 8'shFE
   };

   function automatic logic [PC_W-1:0] sext_off(input branch_off_t off);
      return {{(PC_W-OFF_W){off[OFF_W-1]}}, off};
   endfunction

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch-target offset lookup; isolates table contents from PC logic.
import fetch_unit_pkg::*;

module fetch_unit_branch_lut (
   input  logic [LUT_IDX_W-1:0] idx,
   output branch_off_t          offset
);

   assign offset = BRANCH_LUT[idx];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, Start/Done run sequencing,
// LUT-based branch redirect and a saturating RUN-cycle counter.
import fetch_unit_pkg::*;

module fetch_unit (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               Start,
   input  logic [PC_W-1:0]    StartAddr,
   input  logic [PC_W-1:0]    EndAddr,
   input  logic [INSTR_W-1:0] InstrIn,
   input  logic               Branch,
   input  logic               Zero,
   output logic [PC_W-1:0]    ProgCtr,
   output logic [OP_W-1:0]    Opcode,
   output logic               InstrValid,
   output logic               Done,
   output logic [CNT_W-1:0]   CycleCt
);

   fetch_state_t     state_r;
   logic [PC_W-1:0]  pc_r;
   logic [CNT_W-1:0] cyclect_r;
   logic             done_r;
   logic             valid_r;
   branch_off_t      offset_s;
   logic             taken_s;
   logic [PC_W-1:0]  next_pc_s;
   logic             unused_instr_s;

   fetch_unit_branch_lut branch_lut (
      .idx    (InstrIn[LUT_IDX_W-1:0]),
      .offset (offset_s)
   );

   // Bits between the opcode and the LUT index carry no meaning for fetch.
   assign unused_instr_s = ^InstrIn[INSTR_W-OP_W-1:LUT_IDX_W];

   assign Opcode     = InstrIn[INSTR_W-1 -: OP_W];
   assign ProgCtr    = pc_r;
   assign InstrValid = valid_r;
   assign Done       = done_r;
   assign CycleCt    = cyclect_r;

   // Next sequential or redirected address, modulo 2^PC_W.
   always_comb begin
      taken_s   = Branch & Zero;
      next_pc_s = pc_r + 10'd1;
      if (taken_s) begin
         next_pc_s = pc_r + sext_off(offset_s);
      end else begin
         next_pc_s = pc_r + 10'd1;
      end
   end

   // Run-sequencing FSM; Start overrides every state, completion beats a branch at EndAddr.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r   <= IDLE;
         pc_r      <= 10'd0;
         cyclect_r <= 16'd0;
         done_r    <= 1'b0;
         valid_r   <= 1'b0;
      end else if (Start) begin
         state_r   <= RUN;
         pc_r      <= StartAddr;
         cyclect_r <= 16'd0;
         done_r    <= 1'b0;
         valid_r   <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               valid_r <= 1'b0;
               done_r  <= 1'b0;
            end
            RUN: begin
               if (cyclect_r != {CNT_W{1'b1}}) begin
                  cyclect_r <= cyclect_r + 16'd1;
               end
               if (pc_r == EndAddr) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
                  valid_r <= 1'b0;
               end else begin
                  pc_r    <= next_pc_s;
                  valid_r <= 1'b1;
               end
            end
            DONE: begin
               done_r  <= 1'b1;
               valid_r <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

endmodule
